// File: rtl/sd_rx_ctrl_if.sv
// sd_rx_ctrl_if
// Bundles the host command inputs, the DAT sampling inputs, the FIFO write
// port and the status outputs of sd_rx_ctrl. The clock and reset are not
// part of this interface.
//   master : host/testbench side. Drives start, abort, blk_size, blk_cnt,
//            sd_stb, dat_i and fifo_full.
//   slave  : sd_rx_ctrl side. Drives fifo_wr, fifo_d, clk_hold, busy, done,
//            crc_err, to_err and ovr_err.
interface sd_rx_ctrl_if #(
  parameter int BLKSIZE_W = 12,
  parameter int BLKCNT_W  = 8
) ();
  logic                 start;
  logic                 abort;
  logic [BLKSIZE_W-1:0] blk_size;
  logic [BLKCNT_W-1:0]  blk_cnt;
  logic                 sd_stb;
  logic [3:0]           dat_i;
  logic                 fifo_full;
  logic                 fifo_wr;
  logic [3:0]           fifo_d;
  logic                 clk_hold;
  logic                 busy;
  logic                 done;
  logic                 crc_err;
  logic                 to_err;
  logic                 ovr_err;

  modport master (
    output start, abort, blk_size, blk_cnt, sd_stb, dat_i, fifo_full,
    input  fifo_wr, fifo_d, clk_hold, busy, done, crc_err, to_err, ovr_err
  );

  modport slave (
    input  start, abort, blk_size, blk_cnt, sd_stb, dat_i, fifo_full,
    output fifo_wr, fifo_d, clk_hold, busy, done, crc_err, to_err, ovr_err
  );
endinterface

// File: rtl/sd_rx_ctrl.sv
// sd_rx_ctrl
// Receive-side sequencer for the SD 4-bit data path, running in the FIFO
// write clock domain. A start command arms the sequencer, which then hunts
// for the start bit on all four DAT lines. Each block's nibbles are streamed
// into the FIFO, then the per-line CRC16 values and the end bits are checked.
// This repeats for the programmed block count. While the FIFO is full during
// DATA, clk_hold asks for the card clock to be stopped.
//
// Ports:
//   wclk  : FIFO write clock (the only clock)
//   rst   : asynchronous, active-high reset
//   bus   : sd_rx_ctrl_if.slave. This carries:
//           start/abort      : command inputs
//           blk_size/blk_cnt : transfer geometry, sampled on start
//           sd_stb/dat_i     : card-clock sample strobe and DAT[3:0]
//           fifo_full        : FIFO full flag
//           fifo_wr/fifo_d   : registered FIFO write port
//           clk_hold         : card clock stop request
//           busy/done        : transfer status
//           crc_err/to_err/ovr_err : sticky error flags, cleared on start
//
// Build option: define SD_RX_CRC_EN to include the per-line CRC16 datapath.
// When it is undefined, the CRC phase still consumes 16 strobes, and crc_err
// is set only by the end-bit check.
module sd_rx_ctrl #(
  parameter int BLKSIZE_W = 12,
  parameter int BLKCNT_W  = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic         wclk,
  input  logic         rst,
  sd_rx_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END, S_DONE
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TO_MAX = '1;

  state_t               state, state_nx;
  logic [BLKSIZE_W-1:0] blk_size_q;
  logic [BLKCNT_W-1:0]  blk_left;
  logic [TIMEOUT_W-1:0] to_cnt;
  logic [BLKSIZE_W:0]   nib_cnt;   // nibble index in DATA, bit index in CRC
  logic                 fifo_wr_q;
  logic [3:0]           fifo_d_q;
  logic                 crc_err_q;
  logic                 to_err_q;
  logic                 ovr_err_q;

  logic hold;
  logic accept;
  logic start_bit;
  logic to_hit;
  logic nib_last;
  logic crc_last;
  logic crc_mis;

  // Hold applies only while nibbles are being written to the FIFO.
  // A strobe that arrives during hold is lost.
  assign hold      = bus.fifo_full & (state == S_DATA);
  assign accept    = bus.sd_stb & ~hold;
  assign start_bit = bus.sd_stb & (bus.dat_i == 4'h0);
  assign to_hit    = (to_cnt == TO_MAX);
  assign nib_last  = (nib_cnt == ({blk_size_q, 1'b0} - 1'b1));
  assign crc_last  = (nib_cnt[3:0] == 4'hF);

`ifdef SD_RX_CRC_EN
  logic [15:0] crc_q [4];

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // During the CRC phase, each register is shifted left so that bit 15
  // always holds the next expected bit (MSB first).
  always_ff @(posedge wclk) begin
    for (int n = 0; n < 4; n++) begin
      if (state == S_WAIT_START && start_bit)
        crc_q[n] <= 16'h0000;
      else if (state == S_DATA && accept)
        crc_q[n] <= crc16_step(crc_q[n], bus.dat_i[n]);
      else if (state == S_CRC && bus.sd_stb)
        crc_q[n] <= {crc_q[n][14:0], 1'b0};
    end
  end

  assign crc_mis = (bus.dat_i != {crc_q[3][15], crc_q[2][15], crc_q[1][15], crc_q[0][15]});
`else
  assign crc_mis = 1'b0;
`endif

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:       if (bus.start) state_nx = (bus.blk_cnt == '0) ? S_DONE : S_WAIT_START;
      S_WAIT_START: begin
        if (to_hit)         state_nx = S_DONE;
        else if (start_bit) state_nx = S_DATA;
      end
      S_DATA:       if (accept && nib_last) state_nx = S_CRC;
      S_CRC:        if (bus.sd_stb && crc_last) state_nx = S_END;
      S_END:        if (bus.sd_stb) state_nx = (blk_left == BLKCNT_W'(1)) ? S_DONE : S_WAIT_START;
      S_DONE:       state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
    // Abort overrides everything, including a start issued in the same cycle.
    if (bus.abort) state_nx = S_IDLE;
  end

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      blk_size_q <= '0;
      blk_left   <= '0;
      to_cnt     <= '0;
      nib_cnt    <= '0;
      fifo_wr_q  <= 1'b0;
      fifo_d_q   <= 4'h0;
      crc_err_q  <= 1'b0;
      to_err_q   <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      fifo_wr_q <= 1'b0;
      if (!bus.abort) begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              blk_size_q <= bus.blk_size;
              blk_left   <= bus.blk_cnt;
              to_cnt     <= '0;
              crc_err_q  <= 1'b0;
              to_err_q   <= 1'b0;
              ovr_err_q  <= 1'b0;
            end
          end
          S_WAIT_START: begin
            if (to_hit) begin
              to_err_q <= 1'b1;
            end else if (bus.sd_stb) begin
              if (bus.dat_i == 4'h0) nib_cnt <= '0;
              else                   to_cnt  <= to_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (bus.sd_stb) begin
              if (hold) begin
                ovr_err_q <= 1'b1;
              end else begin
                fifo_wr_q <= 1'b1;
                fifo_d_q  <= bus.dat_i;
                nib_cnt   <= nib_last ? '0 : nib_cnt + 1'b1;
              end
            end
          end
          S_CRC: begin
            if (bus.sd_stb) begin
              nib_cnt <= nib_cnt + 1'b1;
              if (crc_mis) crc_err_q <= 1'b1;
            end
          end
          S_END: begin
            if (bus.sd_stb) begin
              if (bus.dat_i != 4'hF) crc_err_q <= 1'b1;
              blk_left <= blk_left - 1'b1;
              to_cnt   <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.fifo_wr  = fifo_wr_q;
  assign bus.fifo_d   = fifo_d_q;
  assign bus.clk_hold = hold;
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.crc_err  = crc_err_q;
  assign bus.to_err   = to_err_q;
  assign bus.ovr_err  = ovr_err_q;

endmodule

// File: tb/tb_sd_rx_ctrl.sv
// tb_sd_rx_ctrl
// Self-checking bench for sd_rx_ctrl. The DUT is built with TIMEOUT_W=4, so
// that the start-bit timeout is reachable in a short run.
// Transfer cases come from a table. Expected FIFO nibbles are queued as they
// are driven, and compared with the nibbles collected from the FIFO write port.
module tb_sd_rx_ctrl;
  localparam int BW = 12;
  localparam int CW = 8;
  localparam int TW = 4;

  logic wclk = 1'b0;
  logic rst;
  always #5 wclk = ~wclk;

  sd_rx_ctrl_if #(.BLKSIZE_W(BW), .BLKCNT_W(CW)) bus ();

  sd_rx_ctrl #(.BLKSIZE_W(BW), .BLKCNT_W(CW), .TIMEOUT_W(TW)) dut (
    .wclk (wclk),
    .rst  (rst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  got_q[$];
  logic [15:0] mcrc[4];

  typedef struct {
    int   bs;
    int   bc;
    int   flip;
    int   bad_end;
    logic exp_crc;
  } vec_t;

  vec_t vt[5];

  always @(negedge wclk) begin
    if (bus.fifo_wr) begin
      got_q.push_back(bus.fifo_d);
      wr_cnt++;
    end
    if (bus.done) done_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge wclk);
      #1;
    end
  endtask

  task automatic stb(input logic [3:0] d);
    bus.sd_stb = 1'b1;
    bus.dat_i  = d;
    @(posedge wclk);
    #1;
    bus.sd_stb = 1'b0;
    bus.dat_i  = 4'hF;
  endtask

  task automatic do_start(input int bs, input int bc);
    bus.blk_size = BW'(bs);
    bus.blk_cnt  = CW'(bc);
    bus.start    = 1'b1;
    @(posedge wclk);
    #1;
    bus.start    = 1'b0;
  endtask

  task automatic model_clr();
    for (int n = 0; n < 4; n++) mcrc[n] = 16'h0000;
  endtask

  // CRC-16/CCITT (x^16+x^12+x^5+1), init 0, fed one bit per line per nibble.
  task automatic send_nib(input logic [3:0] d);
    logic fb;
    exp_q.push_back(d);
    for (int n = 0; n < 4; n++) begin
      fb = d[n] ^ mcrc[n][15];
      mcrc[n] = {mcrc[n][14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    stb(d);
  endtask

  task automatic send_crc(input int flip_k, input int flip_line);
    logic [3:0] bits;
    for (int k = 0; k < 16; k++) begin
      for (int n = 0; n < 4; n++) bits[n] = mcrc[n][15-k];
      if (k == flip_k) bits[flip_line] = ~bits[flip_line];
      stb(bits);
    end
  endtask

  task automatic drain(input string nm);
    chk({nm, " nibble count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({nm, " nibble"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic run_xfer(input string nm, input int bs, input int bc, input int flip,
                          input int bad_end, input logic exp_crc);
    int w0;
    int d0;
    w0 = wr_cnt;
    d0 = done_cnt;
    do_start(bs, bc);
    chk({nm, " busy after start"}, bus.busy, 1);
    for (int b = 0; b < bc; b++) begin
      stb(4'hF);
      stb(4'h0);
      model_clr();
      for (int j = 0; j < 2 * bs; j++) send_nib(4'((j + 1 + 3 * b) % 16));
      send_crc((flip != 0 && b == 0) ? 8 : -1, 2);
      stb((b == bad_end) ? 4'h7 : 4'hF);
    end
    chk({nm, " done pulse"}, bus.done, 1);
    idle(1);
    chk({nm, " busy after done"}, bus.busy, 0);
    chk({nm, " done low"}, bus.done, 0);
    chk({nm, " writes"}, wr_cnt - w0, 2 * bs * bc);
    chk({nm, " done count"}, done_cnt - d0, 1);
    chk({nm, " crc_err"}, bus.crc_err, exp_crc);
    chk({nm, " to_err"}, bus.to_err, 0);
    chk({nm, " ovr_err"}, bus.ovr_err, 0);
    drain(nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w0;
    int d0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.blk_size  = '0;
    bus.blk_cnt   = '0;
    bus.sd_stb    = 1'b0;
    bus.dat_i     = 4'hF;
    bus.fifo_full = 1'b0;
    rst = 1'b1;

    vt[0] = '{bs: 4, bc: 1, flip: 0, bad_end: -1, exp_crc: 1'b0};
`ifdef SD_RX_CRC_EN
    vt[1] = '{bs: 4, bc: 1, flip: 1, bad_end: -1, exp_crc: 1'b1};
`else
    vt[1] = '{bs: 4, bc: 1, flip: 1, bad_end: -1, exp_crc: 1'b0};
`endif
    vt[2] = '{bs: 8, bc: 3, flip: 0, bad_end: 1,  exp_crc: 1'b1};
    vt[3] = '{bs: 8, bc: 3, flip: 0, bad_end: -1, exp_crc: 1'b0};
    vt[4] = '{bs: 1, bc: 2, flip: 0, bad_end: -1, exp_crc: 1'b0};

    idle(2);
    chk("reset fifo_wr", bus.fifo_wr, 0);
    chk("reset fifo_d", bus.fifo_d, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset flags", {bus.clk_hold, bus.crc_err, bus.to_err, bus.ovr_err}, 0);
    rst = 1'b0;
    idle(1);

    for (int i = 0; i < 5; i++)
      run_xfer($sformatf("vec%0d", i), vt[i].bs, vt[i].bc, vt[i].flip, vt[i].bad_end, vt[i].exp_crc);

    // Start-bit timeout: 15 idle strobes with TIMEOUT_W=4.
    w0 = wr_cnt;
    d0 = done_cnt;
    do_start(4, 1);
    for (int k = 0; k < 14; k++) stb(4'hF);
    chk("timeout early to_err", bus.to_err, 0);
    stb(4'hF);
    chk("timeout not yet done", bus.done, 0);
    idle(1);
    chk("timeout done", bus.done, 1);
    chk("timeout to_err", bus.to_err, 1);
    idle(1);
    chk("timeout busy", bus.busy, 0);
    chk("timeout writes", wr_cnt - w0, 0);
    chk("timeout done count", done_cnt - d0, 1);

    // FIFO full during DATA: the held strobe is dropped and flagged.
    w0 = wr_cnt;
    do_start(4, 1);
    bus.fifo_full = 1'b1;
    #1;
    chk("hold outside data", bus.clk_hold, 0);
    stb(4'hF);
    stb(4'h0);
    model_clr();
    chk("hold in data", bus.clk_hold, 1);
    bus.fifo_full = 1'b0;
    #1;
    chk("hold released", bus.clk_hold, 0);
    for (int j = 1; j <= 3; j++) send_nib(4'(j));
    bus.fifo_full = 1'b1;
    #1;
    chk("hold mid data", bus.clk_hold, 1);
    stb(4'hA);
    chk("ovr_err set", bus.ovr_err, 1);
    bus.fifo_full = 1'b0;
    #1;
    for (int j = 4; j <= 8; j++) send_nib(4'(j));
    send_crc(-1, 0);
    stb(4'hF);
    chk("flow done", bus.done, 1);
    idle(1);
    chk("flow ovr sticky", bus.ovr_err, 1);
    chk("flow crc_err", bus.crc_err, 0);
    chk("flow writes", wr_cnt - w0, 8);
    drain("flow");

    // Abort after the 5th nibble; a dropped strobe leaves ovr_err set.
    w0 = wr_cnt;
    d0 = done_cnt;
    do_start(4, 1);
    stb(4'hF);
    stb(4'h0);
    model_clr();
    for (int j = 1; j <= 4; j++) send_nib(4'(j + 8));
    bus.fifo_full = 1'b1;
    #1;
    stb(4'hC);
    bus.fifo_full = 1'b0;
    #1;
    send_nib(4'hD);
    bus.abort = 1'b1;
    @(posedge wclk);
    #1;
    bus.abort = 1'b0;
    chk("abort busy", bus.busy, 0);
    idle(3);
    chk("abort no done", done_cnt - d0, 0);
    chk("abort stays idle", bus.busy, 0);
    chk("abort writes", wr_cnt - w0, 5);
    chk("abort ovr sticky", bus.ovr_err, 1);
    drain("abort");

    // Start together with abort is ignored.
    bus.abort = 1'b1;
    do_start(4, 1);
    bus.abort = 1'b0;
    chk("start+abort busy", bus.busy, 0);
    chk("start+abort keeps ovr", bus.ovr_err, 1);

    // blk_cnt==0 goes straight to DONE, and start clears the sticky errors.
    do_start(4, 0);
    chk("zero cnt done", bus.done, 1);
    chk("zero cnt busy", bus.busy, 1);
    chk("start clears ovr", bus.ovr_err, 0);
    idle(1);
    chk("zero cnt idle", bus.busy, 0);

    // Asynchronous reset in the middle of DATA.
    do_start(4, 1);
    stb(4'hF);
    stb(4'h0);
    model_clr();
    send_nib(4'h5);
    send_nib(4'h9);
    rst = 1'b1;
    #1;
    chk("midreset fifo_wr", bus.fifo_wr, 0);
    chk("midreset fifo_d", bus.fifo_d, 0);
    chk("midreset busy", bus.busy, 0);
    rst = 1'b0;
    idle(1);
    exp_q.delete();
    got_q.delete();
    run_xfer("post reset", 2, 1, 0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
